// File: rtl/norm_shift_unit.sv
// norm_shift_unit: two-stage FPU adder normalization (leading-zero count, then shift/exponent adjust)
module norm_shift_unit #(
  parameter int SWR = 26,
  parameter int EWR = 8,
  parameter int LZW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           Add_Overflow_i,
  input  logic [SWR-1:0] Data_Result_i,
  input  logic [EWR-1:0] Exp_i,
  output logic [SWR-1:0] Data_o,
  output logic [EWR-1:0] Exp_o,
  output logic [LZW-1:0] LZ_o,
  output logic           Zero_o,
  output logic           Overflow_o,
  output logic           Underflow_o,
  output logic           valid_o
);
  logic [SWR-1:0] d_r, d_n;
  logic [EWR-1:0] e_r, e_n, e_sub;
  logic [LZW-1:0] lz_r, lz_c, lz_n;
  logic [EWR:0]   e_inc, lz_e;
  logic           co_r, v1, ovf, zero, unf;
  // Highest set bit wins because it is visited last
  always_comb begin
    lz_c = LZW'(SWR);
    for (int i = 0; i < SWR; i++)
      if (Data_Result_i[i]) lz_c = LZW'(SWR - 1 - i);
  end
  // Exponent math one bit wide so no wrap reaches Exp_o
  always_comb begin
    e_inc = {1'b0, e_r} + 1'b1;
    lz_e  = (EWR+1)'(lz_r);
    e_sub = e_r - EWR'(lz_r);
    ovf   = co_r && e_inc >= {1'b0, {EWR{1'b1}}};
    zero  = !co_r && d_r == '0;
    unf   = !co_r && !zero && {1'b0, e_r} <= lz_e;
    d_n   = co_r ? (ovf ? '0 : {1'b1, d_r[SWR-1:2], |d_r[1:0]})
                 : (zero || unf) ? '0 : d_r << lz_r;
    e_n   = co_r ? (ovf ? {EWR{1'b1}} : e_inc[EWR-1:0])
                 : (zero || unf) ? '0 : e_sub;
    lz_n  = (co_r || zero) ? '0 : lz_r;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r         <= '0;
      e_r         <= '0;
      lz_r        <= '0;
      co_r        <= 1'b0;
      v1          <= 1'b0;
      Data_o      <= '0;
      Exp_o       <= '0;
      LZ_o        <= '0;
      Zero_o      <= 1'b0;
      Overflow_o  <= 1'b0;
      Underflow_o <= 1'b0;
      valid_o     <= 1'b0;
    end else begin
      v1      <= load_i;
      valid_o <= v1;
      if (load_i) begin
        d_r  <= Data_Result_i;
        e_r  <= Exp_i;
        co_r <= Add_Overflow_i;
        lz_r <= lz_c;
      end
      if (v1) begin
        Data_o      <= d_n;
        Exp_o       <= e_n;
        LZ_o        <= lz_n;
        Zero_o      <= zero;
        Overflow_o  <= ovf;
        Underflow_o <= unf;
      end
    end
  end
endmodule
